// File: rtl/uart_cmd_engine.sv
// rtl/uart_cmd_engine.sv - byte-framed arithmetic command engine
// Parses SOF/OP/A/B/EOF requests, computes, streams ACK/OP/R/STATUS/EOF back.
module uart_cmd_engine #(
  parameter int         OPW = 1,
  parameter logic [7:0] SOF = 8'h0C,
  parameter logic [7:0] EOF = 8'h0A,
  parameter logic [7:0] ACK = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] err_cnt,
  output logic [7:0] drop_cnt
);

  localparam int         NB   = 2*OPW + 1;
  localparam int         OW   = 8*OPW;
  localparam int         RW   = 16*OPW;
  localparam logic [3:0] LEN  = 4'(NB);
  localparam logic [3:0] LAST = 4'(2*OPW + 3);

  typedef enum logic [1:0] {IDLE, RECV, EXEC, SEND} state_t;

  state_t          r_state, w_next;
  logic [7:0]      r_buf [NB];
  logic [3:0]      r_cnt;
  logic [3:0]      r_tx_idx;
  logic [RW-1:0]   r_res;
  logic [7:0]      r_status;
  logic [7:0]      r_op_out;
  logic            r_frame_done;
  logic [7:0]      r_err_cnt;
  logic [7:0]      r_drop_cnt;

  logic [OW-1:0]   w_a, w_b;
  logic [RW-1:0]   w_res;
  logic [7:0]      w_status;
  logic [7:0]      w_op;
  logic            w_hs;

  assign w_hs       = (r_state == SEND) && tx_ready;
  assign tx_valid   = (r_state == SEND);
  assign busy       = (r_state != IDLE);
  assign frame_done = r_frame_done;
  assign err_cnt    = r_err_cnt;
  assign drop_cnt   = r_drop_cnt;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (rx_valid && rx_data == SOF) w_next = RECV;
      RECV: begin
        if (rx_valid) begin
          if (rx_data == SOF)      w_next = RECV;
          else if (rx_data == EOF) w_next = EXEC;
          else if (r_cnt == LEN)   w_next = IDLE;
        end
      end
      EXEC: w_next = SEND;
      SEND: if (w_hs && r_tx_idx == LAST) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operands are stored MSB first right after the OP byte.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < OPW; i++) begin
      w_a[8*(OPW-1-i) +: 8] = r_buf[1+i];
      w_b[8*(OPW-1-i) +: 8] = r_buf[1+OPW+i];
    end
  end

  // Length error dominates; OP is only trustworthy if at least one byte arrived.
  always_comb begin
    w_res    = '0;
    w_status = 8'h00;
    w_op     = (r_cnt != 4'd0) ? r_buf[0] : 8'h00;
    if (r_cnt != LEN) begin
      w_status = 8'h03;
    end else begin
      case (r_buf[0])
        8'h01: w_res = RW'(w_a) + RW'(w_b);
        8'h02: w_res = RW'(w_a) - RW'(w_b);
        8'h03: w_res = RW'(w_a) * RW'(w_b);
        8'h04: begin
          if (w_b == '0) begin
            w_res    = '1;
            w_status = 8'h02;
          end else begin
            w_res = {w_a / w_b, w_a % w_b};
          end
        end
        default: w_status = 8'h01;
      endcase
    end
  end

  always_comb begin
    tx_data = 8'h00;
    if (r_state == SEND) begin
      if (r_tx_idx == 4'd0)                 tx_data = ACK;
      else if (r_tx_idx == 4'd1)            tx_data = r_op_out;
      else if (r_tx_idx == LAST - 4'd1)     tx_data = r_status;
      else if (r_tx_idx == LAST)            tx_data = EOF;
      for (int j = 0; j < 2*OPW; j++)
        if (r_tx_idx == 4'(j + 2)) tx_data = r_res[RW-1-8*j -: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= 4'd0;
      r_tx_idx     <= 4'd0;
      r_res        <= '0;
      r_status     <= 8'h00;
      r_op_out     <= 8'h00;
      r_frame_done <= 1'b0;
      r_err_cnt    <= 8'h00;
      r_drop_cnt   <= 8'h00;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: if (rx_valid && rx_data == SOF) r_cnt <= 4'd0;
        RECV: begin
          if (rx_valid) begin
            if (rx_data == SOF) begin
              r_cnt <= 4'd0;
            end else if (rx_data != EOF && r_cnt != LEN) begin
              for (int i = 0; i < NB; i++)
                if (r_cnt == 4'(i)) r_buf[i] <= rx_data;
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        EXEC: begin
          r_res    <= w_res;
          r_status <= w_status;
          r_op_out <= w_op;
          r_tx_idx <= 4'd0;
          if (rx_valid && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
        SEND: begin
          if (rx_valid && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
          if (w_hs) begin
            if (r_tx_idx == LAST) begin
              r_frame_done <= 1'b1;
              if (r_status != 8'h00 && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            end else begin
              r_tx_idx <= r_tx_idx + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_engine.sv
// tb/tb_uart_cmd_engine.sv - directed self-checking bench for uart_cmd_engine
module tb_uart_cmd_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       frame_done;
  logic [7:0] err_cnt;
  logic [7:0] drop_cnt;

  int         n_total = 0;
  int         n_bad   = 0;
  bit         rnd_rdy = 1'b0;
  logic [7:0] rsp_q[$];
  bit         hold    = 1'b0;
  logic [7:0] held    = 8'h00;

  uart_cmd_engine #(.OPW(1), .SOF(8'h0C), .EOF(8'h0A), .ACK(8'h20)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Record accepted bytes and check hold-while-stalled behaviour.
  initial begin
    forever begin
      @(negedge clk);
      if (hold && !reset) begin
        chk("hold_valid", {31'd0, tx_valid}, 32'd1);
        chk("hold_data", {24'd0, tx_data}, {24'd0, held});
      end
      if (tx_valid && tx_ready) rsp_q.push_back(tx_data);
      hold = tx_valid && !tx_ready && !reset;
      held = tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_req(input logic [63:0] req, input int n);
    rsp_q.delete();
    for (int i = 0; i < n; i++) send_byte(req[8*(n-1-i) +: 8]);
  endtask

  task automatic collect(input string tag, input logic [63:0] exp, input int n);
    bit seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      seen = frame_done;
    end
    chk({tag, "_done"}, {31'd0, seen}, 32'd1);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, frame_done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_len"}, rsp_q.size(), n);
    for (int i = 0; i < n; i++)
      chk({tag, "_byte"}, (i < rsp_q.size()) ? {24'd0, rsp_q[i]} : 32'hDEAD,
          {24'd0, exp[8*(n-1-i) +: 8]});
  endtask

  initial begin
    int sz;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_err", {24'd0, err_cnt}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt}, 32'd0);

    send_req(64'h0C_01_05_03_0A, 5);
    chk("lat_exec", {31'd0, tx_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_send", {31'd0, tx_valid}, 32'd1);
    collect("add", 64'h20_01_00_08_00_0A, 6);

    send_req(64'h0C_03_FF_FF_0A, 5);
    collect("mul", 64'h20_03_FE_01_00_0A, 6);
    send_req(64'h0C_02_03_05_0A, 5);
    collect("sub", 64'h20_02_FF_FE_00_0A, 6);
    send_req(64'h0C_04_07_02_0A, 5);
    collect("div", 64'h20_04_03_01_00_0A, 6);
    chk("err0", {24'd0, err_cnt}, 32'd0);
    send_req(64'h0C_04_07_00_0A, 5);
    collect("div0", 64'h20_04_FF_FF_02_0A, 6);
    chk("err1", {24'd0, err_cnt}, 32'd1);
    send_req(64'h0C_09_01_0A, 4);
    collect("lenerr", 64'h20_09_00_00_03_0A, 6);
    chk("err2", {24'd0, err_cnt}, 32'd2);

    send_req(64'h0C_01_01_02_03_04, 6);
    repeat (10) @(negedge clk);
    chk("ovf_none", rsp_q.size(), 0);
    chk("ovf_idle", {31'd0, busy}, 32'd0);
    chk("ovf_err", {24'd0, err_cnt}, 32'd2);

    send_req(64'h0C_01_0C_02_07_05_0A, 7);
    collect("restart", 64'h20_02_00_02_00_0A, 6);

    rnd_rdy = 1'b1;
    send_req(64'h0C_03_FF_FF_0A, 5);
    collect("rnd_mul", 64'h20_03_FE_01_00_0A, 6);
    send_req(64'h0C_01_05_03_0A, 5);
    send_byte(8'h55);
    send_byte(8'h0C);
    send_byte(8'h0A);
    collect("rnd_inj", 64'h20_01_00_08_00_0A, 6);
    rnd_rdy = 1'b0;
    chk("drop3", {24'd0, drop_cnt}, 32'd3);
    chk("err_keep", {24'd0, err_cnt}, 32'd2);

    send_req(64'h0C_01_05_03_0A, 5);
    for (int k = 0; k < 50 && rsp_q.size() < 2; k++) @(negedge clk);
    chk("rst_wait", (rsp_q.size() >= 2) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_valid", {31'd0, tx_valid}, 32'd0);
    chk("mid_data", {24'd0, tx_data}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_err", {24'd0, err_cnt}, 32'd0);
    chk("mid_drop", {24'd0, drop_cnt}, 32'd0);
    sz = rsp_q.size();
    repeat (10) @(negedge clk);
    chk("mid_quiet", rsp_q.size(), sz);
    send_req(64'h0C_04_07_02_0A, 5);
    collect("post_rst", 64'h20_04_03_01_00_0A, 6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_engine.md
UART_CMD_ENGINE -- requirements
Module: uart_cmd_engine

Interface
REQ-001 SHALL have parameter OPW, default 1, meaning operand width in bytes (legal 1..4).
REQ-002 SHALL have parameter SOF, default 8'h0C, meaning the start-of-frame byte.
REQ-003 SHALL have parameter EOF, default 8'h0A, meaning the end-of-frame byte.
REQ-004 SHALL have parameter ACK, default 8'h20, meaning the response header byte.
REQ-005 SHALL have port clk, input, 1, the clock.
REQ-006 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-007 SHALL have port rx_valid, input, 1, a one-cycle strobe marking a received byte.
REQ-008 SHALL have port rx_data, input, 8, the received byte, qualified by rx_valid.
REQ-009 SHALL have port tx_data, output, 8, the response byte.
REQ-010 SHALL have port tx_valid, output, 1, marking tx_data as valid.
REQ-011 SHALL have port tx_ready, input, 1, the downstream transmitter accepting the byte.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port frame_done, output, 1, a one-cycle pulse when the last response byte is accepted.
REQ-014 SHALL have port err_cnt, output, 8, a saturating count of responses sent with nonzero status.
REQ-015 SHALL have port drop_cnt, output, 8, a saturating count of bytes ignored in the EXEC or SEND states.

Function
REQ-016 SHALL define the request frame as: SOF, OP, A (OPW bytes, MSB first), B (OPW bytes, MSB first), EOF.
REQ-017 SHALL define the response frame as: ACK, OP, R (2*OPW bytes, MSB first), STATUS, EOF.
REQ-018 SHALL implement exactly four states: IDLE, RECV, EXEC and SEND.
REQ-019 IDLE SHALL discard every byte except SOF; SOF SHALL clear the payload counter and move to RECV.
REQ-020 RECV SHALL store each non-EOF byte at index = payload counter, then increment the counter.
REQ-021 RECV SHALL move to EXEC on EOF.
REQ-022 If the counter would exceed 2*OPW+1 in RECV, the block SHALL discard the frame, return to IDLE with no response, and leave err_cnt unchanged.
REQ-023 SOF received inside RECV SHALL restart the frame by clearing the counter and staying in RECV.
REQ-024 EXEC SHALL last exactly one cycle, registering R and STATUS; the first tx_valid SHALL therefore be asserted 2 cycles after the EOF strobe.
REQ-025 OP 8'h01 SHALL produce R = A + B, zero-extended.
REQ-026 OP 8'h02 SHALL produce R = (A - B) modulo 2^(16*OPW).
REQ-027 OP 8'h03 SHALL produce R = A * B, the full product.
REQ-028 OP 8'h04 SHALL produce R = {A / B, A % B}, quotient in the upper OPW bytes and remainder in the lower OPW bytes.
REQ-029 For a valid frame, STATUS SHALL be 8'h00.
REQ-030 For any other OP value, STATUS SHALL be 8'h01 and R SHALL be 0.
REQ-031 For OP 8'h04 with B = 0, STATUS SHALL be 8'h02 and R SHALL be all ones.
REQ-032 If EOF arrives with payload count not equal to 2*OPW+1, STATUS SHALL be 8'h03 and R SHALL be 0.
REQ-033 For the length error, OP SHALL be echoed if received, else 8'h00; this rule SHALL take priority over the other status codes.
REQ-034 SEND SHALL follow a valid/ready handshake: a byte transfers on a cycle with tx_valid && tx_ready.
REQ-035 tx_data SHALL stay stable while tx_valid=1 and tx_ready=0, and tx_valid SHALL NOT drop before the byte transfers.
REQ-036 After the final EOF byte transfers, the block SHALL pulse frame_done for one cycle and return to IDLE on the same edge.
REQ-037 On that same edge, err_cnt SHALL increment (saturating at 255) if STATUS != 0.
REQ-038 Each rx_valid strobe in EXEC or SEND SHALL increment drop_cnt, saturating at 255; such bytes SHALL NOT affect the current frame.
REQ-039 An rx_valid strobe on the frame_done cycle SHALL be processed under IDLE rules.

Reset
REQ-040 reset SHALL take priority over all other inputs on the clock edge where it is sampled.
REQ-041 reset SHALL force state=IDLE, counter=0, tx_valid=0, tx_data=8'h00, busy=0, frame_done=0, err_cnt=0 and drop_cnt=0.
REQ-042 reset asserted mid-RECV or mid-SEND SHALL abort the frame and produce no further tx_valid until a new frame completes.

Verification (OPW=1, tx_ready=1 unless stated)
REQ-043 The bench SHALL drive 0C 01 05 03 0A -> response 20 01 00 08 00 0A, with the first tx_valid 2 cycles after the EOF strobe.
REQ-044 The bench SHALL drive 0C 03 FF FF 0A -> response 20 03 FE 01 00 0A; then 0C 02 03 05 0A -> response 20 02 FF FE 00 0A.
REQ-045 The bench SHALL drive 0C 04 07 02 0A -> response 20 04 03 01 00 0A; then 0C 04 07 00 0A -> response 20 04 FF FF 02 0A with err_cnt=1.
REQ-046 The bench SHALL drive 0C 09 01 0A -> response 20 09 00 00 03 0A; and 0C 01 01 02 03 04 -> no response, state=IDLE.
REQ-047 The bench SHALL toggle tx_ready randomly during SEND -> every response byte held stable until accepted; bytes injected during SEND increment drop_cnt.
REQ-048 The bench SHALL assert reset after the 2nd response byte -> tx_valid=0 next cycle, all counters=0, and the next frame answered correctly.
